// File: rtl/parity_rx_buffer_pkg.sv
// Shared types and helpers for the parity receive buffer: frame widths,
// link-health state encoding and the parity check function.
package parity_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = 9;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        DEGRADED = 2'd1,
        FAULT    = 2'd2
    } link_state_t;

    // A frame is good when the XOR over all nine bits equals the selected sense.
    function automatic logic parity_ok(input logic [FRAME_W-1:0] frame, input logic odd);
        return ((^frame) == odd);
    endfunction

endpackage

// File: rtl/parity_rx_buffer_if.sv
// Frame-in / byte-out handshake bundle of the parity receive buffer.
// master = upstream sender plus downstream consumer, slave = the buffer.
interface parity_rx_buffer_if;
    import parity_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_frame;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_frame,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_frame,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/parity_rx_buffer_sync_fifo.sv
// Small first-word-fall-through FIFO. DEPTH must be a power of two so the
// pointers wrap naturally. Storage is reset so the read port shows zero
// until the first write.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_s;
    logic             pop_s;

    // Guard the strobes so a misbehaving caller cannot corrupt the level.
    always_comb begin
        push_s = push_i && !full_o;
        pop_s  = pop_i && !empty_o;
    end

    // Storage array: write the incoming word at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/parity_rx_buffer.sv
// Parity receive buffer: checks each accepted 9-bit frame, stores good payload
// bytes in a FIFO, drops and counts bad frames, and tracks link health.
// Optional build macro PARITY_RX_LAST_BAD_EN adds the last_bad_frame capture port.
module parity_rx_buffer
    import parity_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ODD_PARITY   = 0,
    parameter int CNT_W        = 8,
    parameter int FAULT_THRESH = 3,
    parameter int RESYNC_GOOD  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parity_rx_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       err_count,
    input  logic                   err_clr,
    output logic                   link_fault
`ifdef PARITY_RX_LAST_BAD_EN
    ,
    output logic [FRAME_W-1:0]     last_bad_frame
`endif
);

    localparam logic              ODD_L   = (ODD_PARITY != 0);
    localparam int                BR_W    = $clog2(FAULT_THRESH + 1);
    localparam int                GR_W    = $clog2(RESYNC_GOOD + 1);
    localparam logic [BR_W-1:0]   FT_L    = BR_W'(FAULT_THRESH);
    localparam logic [GR_W-1:0]   RG_L    = GR_W'(RESYNC_GOOD);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    link_state_t      state_q, state_d;
    logic [BR_W-1:0]  bad_run_q, bad_run_d, bad_run_inc_s;
    logic [GR_W-1:0]  good_run_q, good_run_d, good_run_inc_s;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q;
    logic             full_s, empty_s;
    logic             accept_s, good_s, bad_acc_s, push_s, pop_s;

    // Handshake decode and parity verdict for the frame on the bus this cycle.
    always_comb begin
        accept_s       = bus.in_valid && !full_s;
        good_s         = parity_ok(bus.in_frame, ODD_L);
        bad_acc_s      = accept_s && !good_s;
        pop_s          = !empty_s && bus.out_ready;
        bad_run_inc_s  = bad_run_q + BR_W'(1);
        good_run_inc_s = good_run_q + GR_W'(1);
    end

    // Link-health next state: OK and DEGRADED share the bad-run escalation,
    // FAULT only leaves after an unbroken run of good frames.
    always_comb begin
        state_d    = state_q;
        bad_run_d  = bad_run_q;
        good_run_d = good_run_q;
        push_s     = 1'b0;
        if (accept_s) begin
            case (state_q)
                OK, DEGRADED: begin
                    if (good_s) begin
                        push_s    = 1'b1;
                        state_d   = OK;
                        bad_run_d = '0;
                    end else if (bad_run_inc_s >= FT_L) begin
                        state_d    = FAULT;
                        bad_run_d  = '0;
                        good_run_d = '0;
                    end else begin
                        state_d   = DEGRADED;
                        bad_run_d = bad_run_inc_s;
                    end
                end
                FAULT: begin
                    if (!good_s) begin
                        good_run_d = '0;
                    end else if (good_run_inc_s >= RG_L) begin
                        state_d    = OK;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_run_inc_s;
                    end
                end
                default: begin
                    state_d    = OK;
                    bad_run_d  = '0;
                    good_run_d = '0;
                end
            endcase
        end else begin
            state_d    = state_q;
            bad_run_d  = bad_run_q;
            good_run_d = good_run_q;
        end
    end

    // Error counter: clear wins over increment but still counts a same-cycle bad frame.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = bad_acc_s ? CNT_W'(1) : '0;
        end else if (bad_acc_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // FSM state, run counters, error counter and error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OK;
            bad_run_q   <= '0;
            good_run_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bad_run_q   <= bad_run_d;
            good_run_q  <= good_run_d;
            err_count_q <= err_count_d;
            err_pulse_q <= bad_acc_s;
        end
    end

`ifdef PARITY_RX_LAST_BAD_EN
    logic [FRAME_W-1:0] last_bad_q;

    // Snapshot of the most recent rejected frame; untouched by err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bad_q <= '0;
        end else if (bad_acc_s) begin
            last_bad_q <= bus.in_frame;
        end else begin
            last_bad_q <= last_bad_q;
        end
    end

    assign last_bad_frame = last_bad_q;
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (bus.in_frame[FRAME_W-1:1]),
        .pop_i   (pop_s),
        .rdata_o (bus.out_data),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (fifo_level)
    );

    assign bus.in_ready  = !full_s;
    assign bus.out_valid = !empty_s;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign link_fault    = (state_q == FAULT);

endmodule
